// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage: field extraction, immediate select, illegal detect,
// PC-relative target, held behind a single-entry valid/ready handshake with flush.
module decode_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [PC_W-1:0] out_target,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtIll = 3'd7
    } fmt_e;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    fmt_e            fmt_d;
    logic [XLEN-1:0] imm_d;
    logic [PC_W-1:0] target_d;
    logic            accept;

    logic            valid_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    fmt_e            fmt_q;
    logic [PC_W-1:0] target_q;

    assign imm_i = in_instr[31:20];
    assign imm_s = {in_instr[31:25], in_instr[11:7]};
    assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        fmt_d = FmtIll;
        imm_d = '0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0001111, 7'b1110011: fmt_d = FmtI;
            7'b0011011:             fmt_d = (XLEN == 64) ? FmtI : FmtIll;
            7'b0100011:             fmt_d = FmtS;
            7'b1100011:             fmt_d = FmtB;
            7'b0110111, 7'b0010111: fmt_d = FmtU;
            7'b1101111:             fmt_d = FmtJ;
            7'b0110011:             fmt_d = FmtR;
            7'b0111011:             fmt_d = (XLEN == 64) ? FmtR : FmtIll;
            default:                fmt_d = FmtIll;
        endcase
        // Opcode match already implies 2'b11 today; kept explicit for compressed words.
        if (in_instr[1:0] != 2'b11) begin
            fmt_d = FmtIll;
        end
        case (fmt_d)
            FmtI:    imm_d = XLEN'(imm_i);
            FmtS:    imm_d = XLEN'(imm_s);
            FmtB:    imm_d = XLEN'(imm_b);
            FmtU:    imm_d = XLEN'(imm_u);
            FmtJ:    imm_d = XLEN'(imm_j);
            default: imm_d = '0;
        endcase
    end

    assign target_d = in_pc + imm_d[PC_W-1:0];
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            fmt_q    <= FmtR;
            target_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            instr_q  <= in_instr;
            pc_q     <= in_pc;
            imm_q    <= imm_d;
            fmt_q    <= fmt_d;
            target_q <= target_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = instr_q[6:0];
    assign out_rd      = instr_q[11:7];
    assign out_funct3  = instr_q[14:12];
    assign out_rs1     = instr_q[19:15];
    assign out_rs2     = instr_q[24:20];
    assign out_funct7  = instr_q[31:25];
    assign out_pc      = pc_q;
    assign out_imm     = imm_q;
    assign out_fmt     = fmt_q;
    assign out_target  = target_q;
    assign out_illegal = (fmt_q == FmtIll);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an XLEN=64 and an XLEN=32 instance share stimulus; a per-cycle
// scoreboard checks both against a reference decoder, plus literal expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        in_ready, out_valid, out_illegal;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3, out_fmt;
    logic [63:0] out_imm, out_target, out_pc;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [4:0]  out_rs1_32, out_rs2_32, out_rd_32;
    logic [6:0]  out_opcode32, out_funct7_32;
    logic [2:0]  out_funct3_32, out_fmt32;
    logic [31:0] out_imm32, out_target32, out_pc32;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .PC_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_target(out_target), .out_pc(out_pc),
        .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32),
        .out_ready(out_ready), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_rd(out_rd_32),
        .out_opcode(out_opcode32), .out_funct3(out_funct3_32), .out_funct7(out_funct7_32),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_target(out_target32),
        .out_pc(out_pc32), .out_illegal(out_illegal32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference decoder: immediates from arithmetic shifts of the sign-extended word.
    function automatic void ref_decode(input logic [31:0] w, input bit x64,
                                       output int fmt, output logic [63:0] imm);
        longint s;
        s   = longint'($signed(w));
        fmt = 7;
        imm = '0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin fmt = 1; imm = s >>> 20; end
            7'h1B: if (x64) begin fmt = 1; imm = s >>> 20; end
            7'h23: begin fmt = 2; imm = ((s >>> 25) <<< 5) | longint'(w[11:7]); end
            7'h63: begin
                fmt = 3;
                imm = ((s >>> 31) <<< 12) | (longint'(w[7]) << 11)
                    | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            end
            7'h37, 7'h17: begin fmt = 4; imm = (s >>> 12) <<< 12; end
            7'h6F: begin
                fmt = 5;
                imm = ((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12)
                    | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            end
            7'h33: fmt = 0;
            7'h3B: if (x64) fmt = 0;
            default: fmt = 7;
        endcase
        if (w[1:0] != 2'b11) fmt = 7;
        if (fmt == 7) imm = '0;
    endfunction

    // Scoreboard: holds the raw entry the stage should present; checks at every negedge.
    initial begin
        logic        mv;
        logic [31:0] mw;
        logic [63:0] mpc;
        int          f64, f32;
        logic [63:0] i64, i32, t64;
        logic [31:0] t32;
        mv = 1'b0; mw = '0; mpc = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("out_valid", {63'b0, out_valid}, {63'b0, mv});
                chk("out_valid32", {63'b0, out_valid32}, {63'b0, mv});
                chk("in_ready", {63'b0, in_ready}, {63'b0, (!mv || out_ready)});
                chk("in_ready32", {63'b0, in_ready32}, {63'b0, (!mv || out_ready)});
                if (mv) begin
                    ref_decode(mw, 1'b1, f64, i64);
                    ref_decode(mw, 1'b0, f32, i32);
                    t64 = mpc + i64;
                    t32 = mpc[31:0] + i32[31:0];
                    chk("fields", {32'b0, out_funct7, out_rs2, out_rs1, out_funct3, out_rd,
                                   out_opcode}, {32'b0, mw});
                    chk("fields32", {32'b0, out_funct7_32, out_rs2_32, out_rs1_32,
                                     out_funct3_32, out_rd_32, out_opcode32}, {32'b0, mw});
                    chk("pc", out_pc, mpc);
                    chk("pc32", {32'b0, out_pc32}, {32'b0, mpc[31:0]});
                    chk("imm", out_imm, i64);
                    chk("imm32", {32'b0, out_imm32}, {32'b0, i32[31:0]});
                    chk("fmt", {61'b0, out_fmt}, 64'(f64));
                    chk("fmt32", {61'b0, out_fmt32}, 64'(f32));
                    chk("illegal", {63'b0, out_illegal}, {63'b0, (f64 == 7)});
                    chk("illegal32", {63'b0, out_illegal32}, {63'b0, (f32 == 7)});
                    chk("target", out_target, t64);
                    chk("target32", {32'b0, out_target32}, {32'b0, t32});
                end
            end
            if (rst) begin
                mv = 1'b0; mw = '0; mpc = '0;
            end else if (flush) begin
                mv = 1'b0;
            end else if (in_valid && (!mv || out_ready)) begin
                mv = 1'b1; mw = in_instr; mpc = in_pc;
            end else if (out_ready) begin
                mv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [63:0] pc);
        in_valid  = 1'b1;
        in_instr  = w;
        in_pc     = pc;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] words [12];

    initial begin
        words = '{32'h00000011, 32'h40B50533, 32'h00112623, 32'hFE5212E3, 32'hFFFFF0EF,
                  32'h00001517, 32'h0000100F, 32'h00000073, 32'h7FF08067, 32'h0000000B,
                  32'h8000A183, 32'h0010809B};

        repeat (2) tick();
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt", {61'b0, out_fmt}, 64'd0);
        chk("rst_target", out_target, 64'd0);
        rst   = 1'b0;
        armed = 1'b1;

        offer(32'hFFF00093, 64'h0);
        chk("addi_valid", {63'b0, out_valid}, 64'd1);
        chk("addi_rd", {59'b0, out_rd}, 64'd1);
        chk("addi_fmt", {61'b0, out_fmt}, 64'd1);
        chk("addi_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);

        offer(32'h0020A223, 64'h10);
        chk("sw_fmt", {61'b0, out_fmt}, 64'd2);
        chk("sw_rs1", {59'b0, out_rs1}, 64'd1);
        chk("sw_rs2", {59'b0, out_rs2}, 64'd2);
        chk("sw_imm", out_imm, 64'd4);

        offer(32'hFE000EE3, 64'h100);
        chk("beq_fmt", {61'b0, out_fmt}, 64'd3);
        chk("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_target", out_target, 64'hFC);

        offer(32'h800002B7, 64'h0);
        chk("lui_fmt", {61'b0, out_fmt}, 64'd4);
        chk("lui_imm", out_imm, 64'hFFFFFFFF80000000);
        chk("lui_imm32", {32'b0, out_imm32}, 64'h80000000);

        offer(32'h0080006F, 64'hFFFFFFFFFFFFFFFC);
        chk("jal_fmt", {61'b0, out_fmt}, 64'd5);
        chk("jal_imm", out_imm, 64'd8);
        chk("jal_target", out_target, 64'h4);

        offer(32'h00000000, 64'h20);
        chk("zero_illegal", {63'b0, out_illegal}, 64'd1);
        chk("zero_fmt", {61'b0, out_fmt}, 64'd7);

        offer(32'h0010809B, 64'h0);
        chk("addiw_fmt64", {61'b0, out_fmt}, 64'd1);
        chk("addiw_fmt32", {61'b0, out_fmt32}, 64'd7);
        offer(32'h002080BB, 64'h0);
        chk("addw_fmt64", {61'b0, out_fmt}, 64'd0);
        chk("addw_fmt32", {61'b0, out_fmt32}, 64'd7);

        // Back-to-back stream through a full stage.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            in_pc    = 64'h1000 + 64'(i) * 4;
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Stall for three cycles with a second word waiting.
        offer(32'h00500113, 64'h200);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00718193;
        in_pc     = 64'h204;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
            chk("stall_rd", {59'b0, out_rd}, 64'd2);
            chk("stall_pc", out_pc, 64'h200);
        end
        out_ready = 1'b1;
        tick();
        chk("release_rd", {59'b0, out_rd}, 64'd3);
        chk("release_valid", {63'b0, out_valid}, 64'd1);

        // Flush with a held entry and a word on offer.
        out_ready = 1'b0;
        in_instr  = 32'h00C00213;
        in_pc     = 64'h208;
        flush     = 1'b1;
        tick();
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flush_dropped", {63'b0, out_valid}, 64'd0);

        // Reset mid-stream beats the handshake.
        offer(32'hFFF00093, 64'h40);
        in_valid = 1'b1;
        in_instr = 32'h0020A223;
        rst      = 1'b1;
        tick();
        chk("mrst_valid", {63'b0, out_valid}, 64'd0);
        chk("mrst_pc", out_pc, 64'd0);
        chk("mrst_imm", out_imm, 64'd0);
        chk("mrst_fmt", {61'b0, out_fmt}, 64'd0);
        chk("mrst_rd", {59'b0, out_rd}, 64'd0);
        chk("mrst_target", out_target, 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();

        armed = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
